dense_to_sparse: RTL and testbench

Scans a dense binary polynomial of length r, stored MSB-first in a G_DAT_W-wide memory, and writes the positions of its set bits, in ascending order, into the sparse index memory. It also reports the Hamming weight. It is the writer side of the sparse h memory that the multiplier controller reads. It runs after key-vector sampling and before multiplication.

---
 rtl/dense_to_sparse_pkg.sv | 55 +++++
 rtl/dense_to_sparse_lzc64.sv | 31 +++
 rtl/dense_to_sparse.sv | 123 ++++++++++++
 tb/tb_dense_to_sparse.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dense_to_sparse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dense_to_sparse_pkg
//  Description : Shared sizing constants for the dense-to-sparse converter.
//                Holds the polynomial geometry, the sparse memory geometry,
//                the valid-bit mask of the last dense word and the FSM
//                state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package dense_to_sparse_pkg;

  // Polynomial / dense memory geometry
  localparam int R         = 10163;
  localparam int G_DAT_W   = 64;
  localparam int G_DAT_DEP = 159;
  localparam int G_ADDR_W  = 8;

  // Sparse index memory geometry
  localparam int H_ADDR_W  = 7;
  localparam int H_DAT_W   = 14;
  localparam int H_DAT_DEP = 71;

  // Leading-zero count width for one dense word
  localparam int LZ_W = 6;

  // The last dense word only carries the tail of the polynomial (MSB aligned)
  localparam int LAST_VALID = R - (G_DAT_DEP - 1) * G_DAT_W;  // 51
  localparam logic [G_DAT_W-1:0] LAST_MASK =
      ~((64'd1 << (G_DAT_W - LAST_VALID)) - 64'd1);
  localparam logic [G_ADDR_W-1:0] LAST_WORD = G_ADDR_W'(G_DAT_DEP - 1);

  // Weight limits: writes stop at WEIGHT_MAX, reported weight pins at WEIGHT_SAT
  localparam logic [H_ADDR_W:0] WEIGHT_MAX = (H_ADDR_W + 1)'(H_DAT_DEP);
  localparam logic [H_ADDR_W:0] WEIGHT_SAT = (H_ADDR_W + 1)'(H_DAT_DEP + 1);

  // FSM encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_ADDR = 3'd1;
  localparam state_t ST_WAIT = 3'd2;
  localparam state_t ST_SCAN = 3'd3;
  localparam state_t ST_FIN  = 3'd4;

  // Clear the bit that sits lz positions below the MSB
  function automatic logic [G_DAT_W-1:0] clear_from_msb(
      input logic [G_DAT_W-1:0] word,
      input logic [LZ_W-1:0]    lz
  );
    logic [G_DAT_W-1:0] sel;
    sel = {1'b1, {(G_DAT_W - 1){1'b0}}} >> lz;
    return word & ~sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dense_to_sparse_lzc64.sv
`default_nettype none
// ============================================================================
//  Module      : lzc64
//  Description : Combinational leading-zero counter for one 64-bit dense word.
//  Ports       : din   in  64  word to examine
//                count out 6   number of zeros above the highest set bit
//                zero  out 1   din is all zero (count is then 0, unused)
//  Revision    : 1.0 - initial release
// ============================================================================
module lzc64
  import dense_to_sparse_pkg::*;
(
  input  logic [G_DAT_W-1:0] din,
  output logic [LZ_W-1:0]    count,
  output logic               zero
);

  // Walking upward means the highest set bit is the last to assign
  always_comb begin
    count = '0;
    for (int i = 0; i < G_DAT_W; i++) begin
      if (din[i]) begin
        count = LZ_W'(G_DAT_W - 1 - i);
      end
    end
  end

  assign zero = (din == '0);

endmodule
`default_nettype wire

// File: rtl/dense_to_sparse.sv
`default_nettype none
// ============================================================================
//  Module      : dense_to_sparse
//  Description : Scans a dense MSB-first binary polynomial held in an
//                external synchronous RAM and writes the positions of its
//                set bits, ascending, into the external sparse index RAM.
//                Also reports the Hamming weight and an overflow flag.
//  Ports       : clk        in  1   clock, rising edge
//                rst_b      in  1   asynchronous active-low reset
//                start      in  1   one-cycle start pulse (IDLE only)
//                done       out 1   one-cycle pulse at end of scan
//                weight_err out 1   weight exceeded sparse depth (sticky)
//                weight     out 8   set bits found, saturates at depth+1
//                d_addra    out 8   dense read address
//                d_dina     in  64  dense read data (1-cycle latency)
//                h_addra    out 7   sparse write address
//                h_wea      out 1   sparse write enable
//                h_douta    out 14  bit position written
//  Revision    : 1.0 - initial release
// ============================================================================
module dense_to_sparse
  import dense_to_sparse_pkg::*;
(
  input  logic                clk,
  input  logic                rst_b,
  input  logic                start,
  output logic                done,
  output logic                weight_err,
  output logic [H_ADDR_W:0]   weight,
  output logic [G_ADDR_W-1:0] d_addra,
  input  logic [G_DAT_W-1:0]  d_dina,
  output logic [H_ADDR_W-1:0] h_addra,
  output logic                h_wea,
  output logic [H_DAT_W-1:0]  h_douta
);

  state_t              state;
  logic [G_DAT_W-1:0]  word_reg;
  logic [G_DAT_W-1:0]  word_next;
  logic [LZ_W-1:0]     lz;
  logic                word_zero;
  logic [H_DAT_W-1:0]  bit_idx;
  logic                last_word;

  lzc64 u_lzc (
    .din   (word_reg),
    .count (lz),
    .zero  (word_zero)
  );

  // d_addra doubles as the word counter w
  assign last_word = (d_addra == LAST_WORD);
  assign word_next = clear_from_msb(word_reg, lz);
  // w*64 + lz: w occupies the upper bits, lz the low six
  assign bit_idx   = H_DAT_W'({d_addra, {LZ_W{1'b0}}}) + H_DAT_W'(lz);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= ST_IDLE;
      done       <= 1'b0;
      weight_err <= 1'b0;
      weight     <= '0;
      d_addra    <= '0;
      h_addra    <= '0;
      h_wea      <= 1'b0;
      h_douta    <= '0;
      word_reg   <= '0;
    end else begin
      done  <= 1'b0;
      h_wea <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            weight     <= '0;
            weight_err <= 1'b0;
            d_addra    <= '0;
            state      <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Tail bits beyond r in the last word are not part of the polynomial
          word_reg <= last_word ? (d_dina & LAST_MASK) : d_dina;
          state    <= ST_SCAN;
        end
        ST_SCAN: begin
          if (!word_zero) begin
            if (weight < WEIGHT_MAX) begin
              h_wea   <= 1'b1;
              h_addra <= weight[H_ADDR_W-1:0];
              h_douta <= bit_idx;
              weight  <= weight + 1'b1;
            end else begin
              weight_err <= 1'b1;
              weight     <= WEIGHT_SAT;
            end
            word_reg <= word_next;
          end
          // Leave as soon as the word is exhausted, including this cycle's clear
          if (word_zero || (word_next == '0)) begin
            if (last_word) begin
              state <= ST_FIN;
            end else begin
              d_addra <= d_addra + 1'b1;
              state   <= ST_ADDR;
            end
          end
        end
        ST_FIN: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dense_to_sparse.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dense_to_sparse
//  Description : Self-checking bench for dense_to_sparse. Models the dense
//                RAM, predicts the sparse writes from the dense contents and
//                compares every write, the weight, the error flag and the
//                scan latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dense_to_sparse;
  import dense_to_sparse_pkg::*;

  logic                clk = 1'b0;
  logic                rst_b = 1'b0;
  logic                start = 1'b0;
  logic                done;
  logic                weight_err;
  logic [H_ADDR_W:0]   weight;
  logic [G_ADDR_W-1:0] d_addra;
  logic [G_DAT_W-1:0]  d_dina = '0;
  logic [H_ADDR_W-1:0] h_addra;
  logic                h_wea;
  logic [H_DAT_W-1:0]  h_douta;

  logic [63:0] mem [0:G_DAT_DEP-1];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int wr_cnt  = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  dense_to_sparse dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .start      (start),
    .done       (done),
    .weight_err (weight_err),
    .weight     (weight),
    .d_addra    (d_addra),
    .d_dina     (d_dina),
    .h_addra    (h_addra),
    .h_wea      (h_wea),
    .h_douta    (h_douta)
  );

  // Dense RAM model: one-cycle read latency
  always @(posedge clk) begin
    if (int'(d_addra) < G_DAT_DEP) d_dina <= mem[d_addra];
    else d_dina <= '0;
  end

  // Scoreboard consumer: every sparse write is checked against the prediction
  always @(negedge clk) begin
    int e;
    if (mon_en && h_wea) begin
      if (exp_q.size() == 0) e = -1;
      else e = exp_q.pop_front();
      n_tests++;
      assert (int'(h_douta) === e)
        else begin n_fail++; $error("FAIL h_douta: got %0d expected %0d", h_douta, e); end
      n_tests++;
      assert (int'(h_addra) === wr_cnt)
        else begin n_fail++; $error("FAIL h_addra: got %0d expected %0d", h_addra, wr_cnt); end
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp)
      else begin n_fail++; $error("FAIL %s: got %0d expected %0d", tag, got, exp); end
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [39:0] v;
    v = {done, weight_err, weight, d_addra, h_addra, h_wea, h_douta};
    n_tests++;
    assert (v === 40'd0)
      else begin n_fail++; $error("FAIL %s: got %h expected 0", tag, v); end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < G_DAT_DEP; i++) mem[i] = '0;
  endtask

  task automatic set_pos(input int p);
    mem[p / 64][63 - (p % 64)] = 1'b1;
  endtask

  // Reference model: walk positions 0..R-1 in order
  task automatic build_expected(output int pop, output int nz);
    int last_w;
    pop = 0; nz = 0; last_w = -1;
    exp_q.delete();
    for (int p = 0; p < R; p++) begin
      if (mem[p / 64][63 - (p % 64)]) begin
        if (pop < H_DAT_DEP) exp_q.push_back(p);
        pop++;
        if (p / 64 != last_w) begin nz++; last_w = p / 64; end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_scan(input string tag);
    int pop, nz, cycles, seen, exp_w;
    build_expected(pop, nz);
    wr_cnt = 0;
    mon_en = 1'b1;
    pulse_start();
    cycles = 0; seen = 0;
    while (cycles < 2000 && seen == 0) begin
      @(posedge clk);
      cycles++;
      #1 if (done) seen = 1;
    end
    exp_w = (pop > H_DAT_DEP) ? H_DAT_DEP + 1 : pop;
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, cycles, 3 * G_DAT_DEP + pop - nz + 1);
    check({tag, "_weight"}, int'(weight), exp_w);
    check({tag, "_weight_err"}, int'(weight_err), (pop > H_DAT_DEP) ? 1 : 0);
    check({tag, "_writes"}, wr_cnt, (pop > H_DAT_DEP) ? H_DAT_DEP : pop);
    check({tag, "_left_in_queue"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, int'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_weight_hold"}, int'(weight), exp_w);
    check({tag, "_err_hold"}, int'(weight_err), (pop > H_DAT_DEP) ? 1 : 0);
    mon_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    clear_mem();
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_state");
    @(negedge clk) rst_b = 1'b1;
    repeat (2) @(posedge clk);

    // All-zero memory
    clear_mem();
    run_scan("zero");

    // First and last polynomial positions
    clear_mem();
    set_pos(0);
    set_pos(R - 1);
    run_scan("ends");

    // Only padding bits of the last word set: must be masked away
    clear_mem();
    mem[G_DAT_DEP - 1] = 64'h0000_0000_0000_1FFF;
    run_scan("mask");

    // Full word 5
    clear_mem();
    mem[5] = '1;
    run_scan("full_word");

    // 72 spread bits: overflow of the sparse memory
    clear_mem();
    for (int i = 0; i < 72; i++) set_pos(i * 139 + 5);
    run_scan("overflow");

    // Mixed pattern: several bits in a few words
    clear_mem();
    mem[0]   = 64'h8000_0000_0000_0001;
    mem[77]  = 64'h0123_4567_89AB_CDEF;
    mem[158] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_scan("mixed");

    // Reset in the middle of a scan
    clear_mem();
    mem[3] = '1;
    begin
      int pop, nz;
      build_expected(pop, nz);
    end
    wr_cnt = 0;
    mon_en = 1'b1;
    pulse_start();
    waited = 0;
    while (wr_cnt < 5 && waited < 300) begin
      @(posedge clk);
      waited++;
    end
    check("midscan_reached", (wr_cnt >= 5) ? 1 : 0, 1);
    #2;
    mon_en = 1'b0;
    rst_b = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(posedge clk);
    #1 check_reset_outputs("held_reset");
    @(negedge clk) rst_b = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);

    clear_mem();
    set_pos(777);
    run_scan("after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
